// File: rtl/ghazi_sram_arb_pkg.sv
// Shared types and helpers for the ghazi SRAM arbiter.
// Optional build macro: GHAZI_SRAM_ARB_PERF_EN (adds performance counters to the top).
package ghazi_sram_arb_pkg;

  // Width of the readback starvation counter.
  localparam int unsigned STARVE_CNT_W = 8;

  // Which requester owns the response coming back next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_RB   = 2'd2
  } owner_e;

  // Byte-lane write enable for one 8-bit lane of the core bit mask:
  // the lane is written when the access is a write and any mask bit in it is set.
  function automatic logic wmask_to_be(input logic we, input logic [7:0] lane_mask);
    return we & (|lane_mask);
  endfunction

endpackage

// File: rtl/ghazi_sram_arb_starve.sv
// Saturating readback starvation counter. Raises flip when the readback port
// has been denied STARVE_LIMIT consecutive cycles, giving it priority over core.
module ghazi_sram_arb_starve
  import ghazi_sram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rb_req,
  input  logic                    rb_gnt,
  output logic                    flip,
  output logic [STARVE_CNT_W-1:0] cnt
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] ONE   = {{(STARVE_CNT_W-1){1'b0}}, 1'b1};

  logic [STARVE_CNT_W-1:0] cnt_next;

  // Next count: clear when idle or served, hold at the limit, else count a denied cycle.
  always_comb begin
    cnt_next = cnt;
    if (!rb_req || rb_gnt) begin
      cnt_next = {STARVE_CNT_W{1'b0}};
    end else if (cnt == LIMIT) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + ONE;
    end
  end

  // Counter and registered priority-flip flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= {STARVE_CNT_W{1'b0}};
      flip <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      flip <= (cnt_next == LIMIT);
    end
  end

endmodule

// File: rtl/ghazi_sram_arbiter.sv
// Three-way arbiter for a single-port, 1-cycle-latency word SRAM.
// Requesters: UART programmer (write-only), core adapter, logic-analyzer readback.
// Optional build macro: GHAZI_SRAM_ARB_PERF_EN adds perf_conflict_o / perf_starve_o.
module ghazi_sram_arbiter
  import ghazi_sram_arb_pkg::*;
#(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            prog_we_i,
  input  logic [AW-1:0]   prog_addr_i,
  input  logic [DW-1:0]   prog_wdata_i,
  output logic            prog_gnt_o,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [AW-1:0]   core_addr_i,
  input  logic [DW-1:0]   core_wdata_i,
  input  logic [DW-1:0]   core_wmask_i,
  output logic            core_gnt_o,
  output logic            core_rvalid_o,
  output logic [DW-1:0]   core_rdata_o,
  input  logic            rb_req_i,
  input  logic [AW-1:0]   rb_addr_i,
  output logic            rb_gnt_o,
  output logic            rb_rvalid_o,
  output logic [DW-1:0]   rb_rdata_o,
  input  logic            core_block_i,
  output logic            sram_en_o,
  output logic [DW/8-1:0] sram_we_o,
  output logic [AW-1:0]   sram_addr_o,
  output logic [DW-1:0]   sram_wdata_o,
  input  logic [DW-1:0]   sram_rdata_i
`ifdef GHAZI_SRAM_ARB_PERF_EN
  ,
  output logic [15:0]     perf_conflict_o,
  output logic [15:0]     perf_starve_o
`endif
);

  localparam int unsigned NB = DW / 8;

  logic                    core_req_eff;
  logic                    rb_first;
  logic                    flip;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic [NB-1:0]           core_be;
  owner_e                  owner;
  owner_e                  owner_next;

  // Starvation tracking for the readback port.
  ghazi_sram_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .rb_req (rb_req_i),
    .rb_gnt (rb_gnt_o),
    .flip   (flip),
    .cnt    (starve_cnt)
  );

  // Grant decision: prog always wins; rb beats core only while starved.
  always_comb begin
    core_req_eff = core_req_i & ~core_block_i;
    rb_first     = flip & rb_req_i;
    prog_gnt_o   = prog_we_i;
    core_gnt_o   = ~prog_we_i & core_req_eff & ~rb_first;
    rb_gnt_o     = ~prog_we_i & rb_req_i & (rb_first | ~core_req_eff);
  end

  // Core byte enables derived from the bit mask, one lane at a time.
  always_comb begin
    core_be = {NB{1'b0}};
    for (int i = 0; i < int'(NB); i++) begin
      core_be[i] = wmask_to_be(core_we_i, core_wmask_i[8*i +: 8]);
    end
  end

  // SRAM port mux from the winning requester; all-zero when idle.
  always_comb begin
    sram_en_o    = prog_gnt_o | core_gnt_o | rb_gnt_o;
    sram_we_o    = {NB{1'b0}};
    sram_addr_o  = {AW{1'b0}};
    sram_wdata_o = {DW{1'b0}};
    owner_next   = OWN_NONE;
    if (prog_gnt_o) begin
      sram_we_o    = {NB{1'b1}};
      sram_addr_o  = prog_addr_i;
      sram_wdata_o = prog_wdata_i;
    end else if (core_gnt_o) begin
      sram_we_o    = core_be;
      sram_addr_o  = core_addr_i;
      sram_wdata_o = core_wdata_i;
      owner_next   = OWN_CORE;
    end else if (rb_gnt_o) begin
      sram_addr_o  = rb_addr_i;
      owner_next   = OWN_RB;
    end else begin
      owner_next   = OWN_NONE;
    end
  end

  // Owner tag for the response arriving one cycle after the grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_next;
    end
  end

  // Response steering: rvalid from the tag, rdata gated to zero otherwise.
  // Core writes also return rvalid; their data comes back as zero.
  logic core_wr_pending;

  // Remember whether the outstanding core access was a write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_wr_pending <= 1'b0;
    end else begin
      core_wr_pending <= core_gnt_o & core_we_i;
    end
  end

  // Response outputs decoded from the registered tag.
  always_comb begin
    core_rvalid_o = 1'b0;
    rb_rvalid_o   = 1'b0;
    core_rdata_o  = {DW{1'b0}};
    rb_rdata_o    = {DW{1'b0}};
    case (owner)
      OWN_CORE: begin
        core_rvalid_o = 1'b1;
        if (core_wr_pending) begin
          core_rdata_o = {DW{1'b0}};
        end else begin
          core_rdata_o = sram_rdata_i;
        end
      end
      OWN_RB: begin
        rb_rvalid_o = 1'b1;
        rb_rdata_o  = sram_rdata_i;
      end
      default: begin
        core_rvalid_o = 1'b0;
        rb_rvalid_o   = 1'b0;
      end
    endcase
  end

`ifdef GHAZI_SRAM_ARB_PERF_EN
  logic conflict;
  logic starve_applied;

  // Conflict: two or more live requesters; starve: rb won through the flip.
  always_comb begin
    conflict = (prog_we_i & core_req_eff) | (prog_we_i & rb_req_i) | (core_req_eff & rb_req_i);
    starve_applied = rb_first & ~prog_we_i;
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_conflict_o <= 16'd0;
      perf_starve_o   <= 16'd0;
    end else begin
      if (conflict && (perf_conflict_o != 16'hFFFF)) begin
        perf_conflict_o <= perf_conflict_o + 16'd1;
      end else begin
        perf_conflict_o <= perf_conflict_o;
      end
      if (starve_applied && (perf_starve_o != 16'hFFFF)) begin
        perf_starve_o <= perf_starve_o + 16'd1;
      end else begin
        perf_starve_o <= perf_starve_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ghazi_sram_arbiter.sv
// Directed self-checking bench for ghazi_sram_arbiter with a 1-cycle SRAM model.
module tb_ghazi_sram_arbiter;
  import ghazi_sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_wdata;
  logic        prog_gnt;
  logic        core_req, core_we;
  logic [7:0]  core_addr;
  logic [31:0] core_wdata, core_wmask;
  logic        core_gnt, core_rvalid;
  logic [31:0] core_rdata;
  logic        rb_req;
  logic [7:0]  rb_addr;
  logic        rb_gnt, rb_rvalid;
  logic [31:0] rb_rdata;
  logic        core_block;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [7:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
`ifdef GHAZI_SRAM_ARB_PERF_EN
  logic [15:0] perf_conflict, perf_starve;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ghazi_sram_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata), .prog_gnt_o(prog_gnt),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_wmask_i(core_wmask), .core_gnt_o(core_gnt),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .rb_req_i(rb_req), .rb_addr_i(rb_addr), .rb_gnt_o(rb_gnt),
    .rb_rvalid_o(rb_rvalid), .rb_rdata_o(rb_rdata),
    .core_block_i(core_block),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
`ifdef GHAZI_SRAM_ARB_PERF_EN
    , .perf_conflict_o(perf_conflict), .perf_starve_o(perf_starve)
`endif
  );

  // Single-port SRAM model: byte writes, read data one cycle after enable.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (sram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
      sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  pre_addr [0:4];
  logic [31:0] pre_data [0:4];

  initial begin
    pre_addr[0] = 8'h06; pre_data[0] = 32'h0600CAFE;
    pre_addr[1] = 8'h12; pre_data[1] = 32'hDEADBEEF;
    pre_addr[2] = 8'h20; pre_data[2] = 32'hAABBCCDD;
    pre_addr[3] = 8'h30; pre_data[3] = 32'h30303030;
    pre_addr[4] = 8'h40; pre_data[4] = 32'h4040ABCD;

    rst_n = 1'b0; prog_we = 1'b0; prog_addr = 8'h00; prog_wdata = 32'h0;
    core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 32'h0; core_wmask = 32'h0;
    rb_req = 1'b0; rb_addr = 8'h00; core_block = 1'b0;

    // Reset state
    #3;
    chk("rst_prog_gnt", prog_gnt, 1'b0);
    chk("rst_core_rvalid", core_rvalid, 1'b0);
    chk("rst_rb_rvalid", rb_rvalid, 1'b0);
    chk("rst_core_rdata", core_rdata, 32'h0);
    chk("rst_rb_rdata", rb_rdata, 32'h0);
    chk("rst_sram_en", sram_en, 1'b0);
    chk("rst_cnt", dut.u_starve.cnt, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Preload through the programmer port
    for (int k = 0; k < 5; k++) begin
      prog_we = 1'b1; prog_addr = pre_addr[k]; prog_wdata = pre_data[k];
      #1;
      chk("pre_prog_gnt", prog_gnt, 1'b1);
      chk("pre_sram_we", sram_we, 4'hF);
      tick();
    end
    prog_we = 1'b0;

    // Core read of 0x12
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h12;
    #1;
    chk("rd_gnt", core_gnt, 1'b1);
    chk("rd_sram_we", sram_we, 4'h0);
    chk("rd_sram_addr", sram_addr, 8'h12);
    tick(); core_req = 1'b0; #1;
    chk("rd_rvalid", core_rvalid, 1'b1);
    chk("rd_rdata", core_rdata, 32'hDEADBEEF);

    // Programmer and core together
    prog_we = 1'b1; prog_addr = 8'h05; prog_wdata = 32'h55AA55AA;
    core_req = 1'b1; core_addr = 8'h06;
    #1;
    chk("pc_prog_gnt", prog_gnt, 1'b1);
    chk("pc_core_gnt", core_gnt, 1'b0);
    chk("pc_we", sram_we, 4'hF);
    chk("pc_addr", sram_addr, 8'h05);
    tick(); prog_we = 1'b0; #1;
    chk("pc_c1_rvalid", core_rvalid, 1'b0);
    chk("pc_c1_core_gnt", core_gnt, 1'b1);
    chk("pc_c1_addr", sram_addr, 8'h06);
    tick(); core_req = 1'b0; #1;
    chk("pc_c2_rvalid", core_rvalid, 1'b1);
    chk("pc_c2_rdata", core_rdata, 32'h0600CAFE);
    tick();
    chk("pc_c3_rvalid", core_rvalid, 1'b0);
    core_req = 1'b1; core_addr = 8'h05;
    tick(); core_req = 1'b0; #1;
    chk("pc_prog_data", core_rdata, 32'h55AA55AA);

    // Core masked write to 0x20
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h20;
    core_wdata = 32'h11223344; core_wmask = 32'h00FF0000;
    #1;
    chk("wr_gnt", core_gnt, 1'b1);
    chk("wr_sram_we", sram_we, 4'b0100);
    tick(); core_req = 1'b0; core_we = 1'b0; core_wmask = 32'h0; #1;
    chk("wr_rvalid", core_rvalid, 1'b1);
    chk("wr_rdata", core_rdata, 32'h0);
    core_req = 1'b1; core_addr = 8'h20;
    tick(); core_req = 1'b0; #1;
    chk("wr_readback", core_rdata, 32'hAABB_CCDD & 32'hFF00FFFF | 32'h00220000);

    // Starvation: core and rb held together
    core_req = 1'b1; core_addr = 8'h12; rb_req = 1'b1; rb_addr = 8'h30;
    for (int c = 0; c < 17; c++) begin
      #1;
      chk("st_rb_gnt", rb_gnt, (c == 15) ? 1'b1 : 1'b0);
      chk("st_core_gnt", core_gnt, (c == 15) ? 1'b0 : 1'b1);
      if (c == 16) begin
        chk("st_cnt_clear", dut.u_starve.cnt, 8'd0);
        chk("st_rb_rvalid", rb_rvalid, 1'b1);
        chk("st_rb_rdata", rb_rdata, 32'h30303030);
        chk("st_core_rvalid", core_rvalid, 1'b0);
      end
      tick();
    end
    core_req = 1'b0; rb_req = 1'b0;
    tick();

    // Core blocked for 10 cycles
    core_block = 1'b1; core_req = 1'b1; core_addr = 8'h12;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("blk_core_gnt", core_gnt, 1'b0);
      chk("blk_sram_en", sram_en, 1'b0);
      tick();
    end
    chk("blk_rvalid", core_rvalid, 1'b0);
    rb_req = 1'b1; rb_addr = 8'h40;
    #1;
    chk("blk_rb_gnt", rb_gnt, 1'b1);
    tick(); rb_req = 1'b0; #1;
    chk("blk_rb_rvalid", rb_rvalid, 1'b1);
    chk("blk_rb_rdata", rb_rdata, 32'h4040ABCD);
    chk("blk_core_rvalid2", core_rvalid, 1'b0);
    core_req = 1'b0; core_block = 1'b0;
    tick();

    // Block rising with a core read outstanding
    core_req = 1'b1; core_addr = 8'h06;
    #1;
    chk("br_gnt", core_gnt, 1'b1);
    tick(); core_req = 1'b0; core_block = 1'b1; #1;
    chk("br_rvalid", core_rvalid, 1'b1);
    chk("br_rdata", core_rdata, 32'h0600CAFE);
    core_block = 1'b0;
    tick();

    // Reset during an in-flight core read
    core_req = 1'b1; core_addr = 8'h12;
    #1;
    chk("rs_gnt", core_gnt, 1'b1);
    tick(); core_req = 1'b0; rst_n = 1'b0; #1;
    chk("rs_rvalid", core_rvalid, 1'b0);
    chk("rs_rdata", core_rdata, 32'h0);
    chk("rs_cnt", dut.u_starve.cnt, 8'd0);
    chk("rs_tag", dut.owner, OWN_NONE);
    tick(); rst_n = 1'b1;
    tick();
    chk("rs_rvalid_after", core_rvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ghazi_sram_arbiter.md
Name: ghazi_sram_arbiter

Overview:
Arbitrates one single-port, 1-cycle-latency DFFRAM word SRAM among three requesters:
- the UART boot programmer, write-only;
- the core TL/SRAM adapter port, req/gnt/rvalid;
- a logic-analyzer readback port, read-only.

Replaces ad-hoc muxing of SRAM address, data and enable at the top level. Also generates per-requester grants and read-data-valid strobes. One instance each for the instruction and data SRAMs.

Parameters:
AW, 8, SRAM word-address width.
DW, 32, data width; must be a multiple of 8.
STARVE_LIMIT, 15, consecutive denied cycles before readback port gets one-shot top priority (1..255).

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
prog_we_i  in  1  programmer write strobe; full-word write.
prog_addr_i  in  AW  programmer address.
prog_wdata_i  in  DW  programmer write data.
prog_gnt_o  out  1  programmer granted this cycle.
core_req_i  in  1  core request; held until core_gnt_o.
core_we_i  in  1  core write enable.
core_addr_i  in  AW  core address.
core_wdata_i  in  DW  core write data.
core_wmask_i  in  DW  core bit mask.
core_gnt_o  out  1  core granted this cycle.
core_rvalid_o  out  1  core response valid.
core_rdata_o  out  DW  core read data.
rb_req_i  in  1  readback request; held until rb_gnt_o.
rb_addr_i  in  AW  readback address.
rb_gnt_o  out  1  readback granted.
rb_rvalid_o  out  1  readback data valid.
rb_rdata_o  out  DW  readback data.
core_block_i  in  1  1 = core port locked out (programming in progress).
sram_en_o  out  1  SRAM enable.
sram_we_o  out  DW/8  SRAM byte write enables.
sram_addr_o  out  AW  SRAM address.
sram_wdata_o  out  DW  SRAM write data.
sram_rdata_i  in  DW  SRAM read data; valid the cycle after a read enable.

Behaviour:
- Grant logic is combinational: at most one grant per cycle.
- Priority, normal case: prog > core > rb.
  - If the starvation counter equals STARVE_LIMIT: rb > core. prog stays highest.
  - When core_block_i=1, core_gnt_o=0 and the core request is ignored. No rvalid is issued for it.
- SRAM drive:
  - sram_en_o = any grant.
  - Address, wdata and WE are muxed from the winner. Idle: address and wdata 0, WE 0.
  - prog: WE all ones.
  - core: WE[i] = core_we_i & |core_wmask_i[8i+7:8i].
  - rb: WE 0.
- Response pipeline: registered owner tag (NONE/CORE/RB) is captured at each grant.
  - Next cycle, core_rvalid_o=1 when the tag is CORE, for reads and writes alike.
  - Next cycle, rb_rvalid_o=1 when the tag is RB.
  - rdata outputs = sram_rdata_i when the matching rvalid=1, else 0.
  - Core write: rvalid pulses, rdata 0.
- Back-to-back grants every cycle are allowed. Throughput is 1 access/cycle.
- Starvation counter, 8-bit:
  - Increments when rb_req_i=1 and rb is not granted.
  - Saturates at STARVE_LIMIT.
  - Clears on rb grant or when rb_req_i=0.
  - If prog wins while the counter is at the limit, the counter holds.
- Simultaneous prog and core: prog_gnt_o=1, core_gnt_o=0. Core keeps its request asserted. No rvalid that cycle.
- Reset, asserted asynchronously:
  - All grants, rvalids and rdata are 0; the owner tag is NONE; the counter is 0.
  - An access in flight when reset asserts is dropped; no rvalid follows.
- core_block_i rising while a core read is outstanding: that read's rvalid is still delivered next cycle.

Optional Feature:
GHAZI_SRAM_ARB_PERF_EN.
- Defined: adds outputs perf_conflict_o[15:0] and perf_starve_o[15:0], reset 0, saturating.
  - perf_conflict_o counts cycles with at least 2 requesters pending.
  - perf_starve_o counts cycles in which starvation priority was applied.
- Undefined: ports and counters are absent. Grant behaviour is identical.

Decomposition:
- Package ghazi_sram_arb_pkg holds:
  - owner_e enum {OWN_NONE, OWN_CORE, OWN_RB};
  - the byte-enable helper function wmask_to_be;
  - the STARVE_CNT_W=8 constant.
- One sub-module, ghazi_sram_arb_starve, holds the saturating starvation counter and emits the priority-flip flag.

Test Plan:
- Core read only, addr 0x12 with SRAM holding 0xDEADBEEF → gnt same cycle, core_rvalid_o=1 and rdata=0xDEADBEEF next cycle, sram_we_o=0.
- prog_we_i and core_req_i together, addr 0x05/0x06 → cycle 0 prog granted with sram_we_o=4'hF at 0x05; cycle 1 core granted; core rvalid cycle 2 only.
- Core write with wmask 0x00FF0000 → sram_we_o=4'b0100; core_rvalid_o=1 next cycle with rdata 0.
- Core req held continuously plus rb_req held, STARVE_LIMIT=15 → rb granted on cycle 15; counter then 0; core granted cycles 16 onward.
- core_block_i=1 with core_req_i=1 for 10 cycles → core_gnt_o stays 0 and no SRAM access; rb requests still served.
- rst_ni asserted the cycle after a core read grant → core_rvalid_o=0 immediately and after reset release; counter and tag read 0.
